// File: rtl/ashr_iter_unit.sv
// Iterative arithmetic-right-shift unit (a >>>= n) with a valid/ready handshake, one bit per cycle.
// Optional sticky (shifted-out OR) register enabled by defining ASHR_ITER_STICKY_EN.
module ashr_iter_unit #(
  parameter int W  = 8,
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic [SW-1:0] in_amt,
  input  logic          in_signed,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [W-1:0]  out_orig,
  output logic [SW-1:0] out_amt,
  output logic          out_sticky
);

  localparam int CW   = $clog2(W + 1);
  localparam int CMPW = (SW > CW) ? SW : CW;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state;
  state_t         nextState;
  logic [W-1:0]   work;
  logic [W-1:0]   origReg;
  logic [SW-1:0]  amtReg;
  logic           fillReg;
  logic [CW-1:0]  cnt;
  logic           accept;
  logic           inFill;
  logic [CMPW-1:0] amtWide;
  logic [CW-1:0]  eff;

  assign accept    = in_valid && in_ready;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = work;
  assign out_orig  = origReg;
  assign out_amt   = amtReg;
  assign inFill    = in_signed ? in_data[W-1] : 1'b0;

  // Compare at a width that holds both in_amt and W so large amounts saturate instead of wrapping.
  assign amtWide = CMPW'(in_amt);
  assign eff     = (amtWide >= CMPW'(W)) ? CW'(W) : CW'(in_amt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = (eff > CW'(1)) ? SHIFT : DONE;
      SHIFT:   if (cnt == CW'(1)) nextState = DONE;
      DONE:    if (out_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // The first shift happens on the accept edge itself, so cnt holds the shifts still remaining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work    <= '0;
      origReg <= '0;
      amtReg  <= '0;
      fillReg <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            origReg <= in_data;
            amtReg  <= in_amt;
            fillReg <= inFill;
            if (eff == '0) begin
              work <= in_data;
              cnt  <= '0;
            end else begin
              work <= {inFill, in_data[W-1:1]};
              cnt  <= eff - CW'(1);
            end
          end
        end
        SHIFT: begin
          work <= {fillReg, work[W-1:1]};
          cnt  <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef ASHR_ITER_STICKY_EN
  logic stickyReg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stickyReg <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (accept) stickyReg <= (eff == '0) ? 1'b0 : in_data[0];
        SHIFT:   stickyReg <= stickyReg | work[0];
        default: ;
      endcase
    end
  end

  assign out_sticky = stickyReg;
`else
  assign out_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_ashr_iter_unit.sv
// Self-checking bench for ashr_iter_unit (W=8, SW=4): directed cases plus randomized transactions
// against a plain-arithmetic reference model.
module tb_ashr_iter_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [3:0] in_amt;
  logic       in_signed;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [7:0] out_orig;
  logic [3:0] out_amt;
  logic       out_sticky;

  int errorCount = 0;
  int checkCount = 0;
  bit stickyOn;

  ashr_iter_unit #(.W(8), .SW(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_orig(out_orig), .out_amt(out_amt), .out_sticky(out_sticky)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int effOf(input int amt);
    return (amt >= 8) ? 8 : amt;
  endfunction

  function automatic logic [7:0] modelShift(input logic [7:0] a, input int amt, input bit sgn);
    logic signed [7:0] sa;
    int e;
    sa = a;
    e = effOf(amt);
    if (sgn) return sa >>> e;
    return a >> e;
  endfunction

  function automatic logic modelSticky(input logic [7:0] a, input int amt);
    int mask;
    mask = (1 << effOf(amt)) - 1;
    return stickyOn && ((int'(a) & mask) != 0);
  endfunction

  // One full transaction: accept, measure latency, check results, optionally stall, then drain.
  task automatic applyStimulus(input logic [7:0] a, input int amt, input bit sgn, input int hold);
    int waitCnt;
    int lat;
    logic [7:0] expData;
    logic expSticky;
    int expLat;
    expData   = modelShift(a, amt, sgn);
    expSticky = modelSticky(a, amt);
    expLat    = (effOf(amt) < 1) ? 1 : effOf(amt);
    waitCnt = 0;
    while (!in_ready && waitCnt < 40) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    checkOutput("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_data   = a;
    in_amt    = 4'(amt);
    in_signed = sgn;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_data   = 8'($urandom);
    in_amt    = 4'($urandom);
    in_signed = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'(expLat));
    checkOutput("out_data", 32'(out_data), 32'(expData));
    checkOutput("out_orig", 32'(out_orig), 32'(a));
    checkOutput("out_amt", 32'(out_amt), 32'(amt));
    checkOutput("out_sticky", 32'(out_sticky), 32'(expSticky));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_ready", 32'(in_ready), 32'd0);
      checkOutput("hold_data", 32'(out_data), 32'(expData));
      checkOutput("hold_orig", 32'(out_orig), 32'(a));
      checkOutput("hold_amt", 32'(out_amt), 32'(amt));
      checkOutput("hold_sticky", 32'(out_sticky), 32'(expSticky));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("drain_ready", 32'(in_ready), 32'd1);
    checkOutput("drain_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
`ifdef ASHR_ITER_STICKY_EN
    stickyOn = 1'b1;
`else
    stickyOn = 1'b0;
`endif
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_amt = '0;
    in_signed = 1'b0;
    out_ready = 1'b0;
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_out_orig", 32'(out_orig), 32'd0);
    checkOutput("rst_out_amt", 32'(out_amt), 32'd0);
    checkOutput("rst_out_sticky", 32'(out_sticky), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    applyStimulus(8'h90, 2, 1'b1, 0);
    applyStimulus(8'h90, 2, 1'b0, 0);
    applyStimulus(8'hA5, 0, 1'b1, 0);
    applyStimulus(8'h81, 15, 1'b1, 0);
    applyStimulus(8'h81, 15, 1'b0, 0);
    applyStimulus(8'h7F, 8, 1'b1, 0);
    applyStimulus(8'h03, 1, 1'b0, 0);
    applyStimulus(8'hC3, 3, 1'b1, 5);
    applyStimulus(8'h5A, 4, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      applyStimulus(8'($urandom_range(0, 255)), $urandom_range(0, 15),
                    1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    // Asynchronous reset in the middle of a 6-bit shift.
    in_valid  = 1'b1;
    in_data   = 8'hB7;
    in_amt    = 4'd6;
    in_signed = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    checkOutput("mid_busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_ready", 32'(in_ready), 32'd1);
    checkOutput("mid_rst_data", 32'(out_data), 32'd0);
    checkOutput("mid_rst_orig", 32'(out_orig), 32'd0);
    checkOutput("mid_rst_amt", 32'(out_amt), 32'd0);
    checkOutput("mid_rst_sticky", 32'(out_sticky), 32'd0);
    @(posedge clk); #1;
    checkOutput("mid_rst_hold_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    applyStimulus(8'h40, 1, 1'b1, 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
